// File: rtl/drum_mem_unit.sv
// Rotating-drum word store: an accepted request completes when its sector passes under the head, with done one cycle later.
// One request at a time; strobes arriving while busy are dropped. DRUM_LATENCY_EN enables the rotational wait; without it, done comes 2 cycles after the request.
module drum_mem_unit #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 30,
  parameter int SECTOR_W    = 5,
  parameter int WORD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                do_mem_read_from_ac,
  input  logic                do_mem_write_from_ac,
  input  logic [ADDR_W-1:0]   addr_from_sel,
  input  logic [DATA_W-1:0]   write_data_from_ac,
  output logic [DATA_W-1:0]   read_data_to_ac,
  output logic                mem_done_to_ac,
  output logic                mem_busy_to_ac,
  output logic [SECTOR_W-1:0] drum_pos_to_pnl
);

  localparam int SUB_W = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SUB_W-1:0]    sub_q, sub_d;
  logic [SECTOR_W-1:0] sector_q, sector_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   rdata_q;
  logic                sub_last;
  logic                access_ok;
  logic                access;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Position counter free-runs regardless of the request state.
  always_comb begin
    sub_last = (sub_q == SUB_W'(WORD_CYCLES - 1));
    sub_d    = sub_last ? '0 : sub_q + SUB_W'(1);
    sector_d = sub_last ? sector_q + SECTOR_W'(1) : sector_q;
  end

`ifdef DRUM_LATENCY_EN
  logic sector_hit;
  // WAIT is entered after the latch edge, so a match during the latch cycle is missed.
  assign sector_hit = (sector_q == addr_q[SECTOR_W-1:0]) && (sub_q == '0);
  assign access_ok  = sector_hit;
`else
  assign access_ok  = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (do_mem_read_from_ac || do_mem_write_from_ac) begin
          addr_d  = addr_from_sel;
          wdata_d = write_data_from_ac;
          wr_d    = do_mem_write_from_ac;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (access_ok) begin
          access  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sub_q    <= '0;
      sector_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      sub_q    <= sub_d;
      sector_q <= sector_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      if (access && !wr_q) begin
        rdata_q <= mem[addr_q];
      end
    end
  end

  // Store contents survive reset; a reset during the access cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && access && wr_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign read_data_to_ac = rdata_q;
  assign mem_done_to_ac  = (state_q == ST_DONE);
  assign mem_busy_to_ac  = (state_q != ST_IDLE);
  assign drum_pos_to_pnl = sector_q;

endmodule

// File: tb/tb_drum_mem_unit.sv
// Directed bench for drum_mem_unit; expected latency follows DRUM_LATENCY_EN as seen by this compile.
module tb_drum_mem_unit;

  logic        clk;
  logic        reset;
  logic        do_mem_read_from_ac;
  logic        do_mem_write_from_ac;
  logic [11:0] addr_from_sel;
  logic [29:0] write_data_from_ac;
  logic [29:0] read_data_to_ac;
  logic        mem_done_to_ac;
  logic        mem_busy_to_ac;
  logic [4:0]  drum_pos_to_pnl;

  int checks = 0;
  int errors = 0;
  int m_cyc  = 0;

  drum_mem_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .do_mem_read_from_ac  (do_mem_read_from_ac),
    .do_mem_write_from_ac (do_mem_write_from_ac),
    .addr_from_sel        (addr_from_sel),
    .write_data_from_ac   (write_data_from_ac),
    .read_data_to_ac      (read_data_to_ac),
    .mem_done_to_ac       (mem_done_to_ac),
    .mem_busy_to_ac       (mem_busy_to_ac),
    .drum_pos_to_pnl      (drum_pos_to_pnl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rotation: clocks since reset; 64 clocks per turn, 2 per sector.
  always @(posedge clk) begin
    if (reset) m_cyc <= 0;
    else       m_cyc <= m_cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pos(input int target);
    int n;
    n = 0;
    while ((m_cyc % 64) != target && n < 200) begin
      step();
      n++;
    end
    chk("wait_pos", 32'(m_cyc % 64), 32'(target));
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [11:0] a,
                        input logic [29:0] d, input logic [29:0] exp_rd, input string tag);
    int c, k, lat, n;
    bit seen;
    c = m_cyc % 64;
    chk({tag, "_pos"}, 32'(drum_pos_to_pnl), 32'(c / 2));
`ifdef DRUM_LATENCY_EN
    k = (int'(a[4:0]) * 2 - c + 64) % 64;
    if (k == 0) k = 64;
    lat = k + 1;
`else
    k   = 0;
    lat = 2;
`endif
    do_mem_read_from_ac  = rd;
    do_mem_write_from_ac = wr;
    addr_from_sel        = a;
    write_data_from_ac   = d;
    step();
    do_mem_read_from_ac  = 1'b0;
    do_mem_write_from_ac = 1'b0;
    chk({tag, "_busy"}, 32'(mem_busy_to_ac), 32'd1);
    n    = 1;
    seen = 1'b0;
    while (!seen && n <= 200) begin
      if (mem_done_to_ac) seen = 1'b1;
      else begin
        step();
        n++;
      end
    end
    chk({tag, "_latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(lat));
    chk({tag, "_rdata"}, 32'(read_data_to_ac), 32'(exp_rd));
    step();
    chk({tag, "_done_off"}, {30'd0, mem_done_to_ac, mem_busy_to_ac}, 32'd0);
  endtask

  initial begin
    int dones;
    reset                = 1'b1;
    do_mem_read_from_ac  = 1'b0;
    do_mem_write_from_ac = 1'b0;
    addr_from_sel        = '0;
    write_data_from_ac   = '0;
    repeat (3) step();
    chk("reset_rdata", 32'(read_data_to_ac), 32'd0);
    chk("reset_flags", {30'd0, mem_done_to_ac, mem_busy_to_ac}, 32'd0);
    chk("reset_pos", 32'(drum_pos_to_pnl), 32'd0);
    reset = 1'b0;

    // First post-reset cycle is sector 0 sub 0; with rotation the write takes 11 cycles.
    do_req(1'b0, 1'b1, 12'h005, 30'h15555555, 30'h0, "wr005");
    do_req(1'b1, 1'b0, 12'h005, 30'h0, 30'h15555555, "rd005");

    do_req(1'b0, 1'b1, 12'h025, 30'h0ABCDEF0, 30'h15555555, "wr025");
    wait_pos(10);
    do_req(1'b1, 1'b0, 12'h025, 30'h0, 30'h0ABCDEF0, "rd025_miss");

    do_req(1'b1, 1'b1, 12'h0A3, 30'h3FFFFFFF, 30'h0ABCDEF0, "both0A3");
    do_req(1'b1, 1'b0, 12'h0A3, 30'h0, 30'h3FFFFFFF, "rd0A3");

    do_req(1'b0, 1'b1, 12'h010, 30'h12345678, 30'h3FFFFFFF, "wr010");

    // Write strobe held while busy must be ignored.
    do_mem_read_from_ac = 1'b1;
    addr_from_sel       = 12'h005;
    step();
    do_mem_read_from_ac = 1'b0;
    dones = 0;
    for (int i = 0; i < 150; i++) begin
      if (mem_done_to_ac) dones++;
      do_mem_write_from_ac = mem_busy_to_ac;
      addr_from_sel        = 12'h010;
      write_data_from_ac   = 30'h0;
      step();
    end
    do_mem_write_from_ac = 1'b0;
    chk("busy_ignore_dones", 32'(dones), 32'd1);
    chk("busy_ignore_rdata", 32'(read_data_to_ac), 32'h15555555);
    do_req(1'b1, 1'b0, 12'h010, 30'h0, 30'h12345678, "rd010");

    // Reset during WAIT abandons the write.
    do_mem_write_from_ac = 1'b1;
    addr_from_sel        = 12'h005;
    write_data_from_ac   = 30'h0;
    step();
    do_mem_write_from_ac = 1'b0;
    chk("rst_wait_busy", 32'(mem_busy_to_ac), 32'd1);
    reset = 1'b1;
    step();
    chk("rst_wait_rdata", 32'(read_data_to_ac), 32'd0);
    chk("rst_wait_flags", {30'd0, mem_done_to_ac, mem_busy_to_ac}, 32'd0);
    chk("rst_wait_pos", 32'(drum_pos_to_pnl), 32'd0);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      if (mem_done_to_ac) dones++;
      step();
    end
    chk("rst_wait_nodone", 32'(dones), 32'd0);
    do_req(1'b1, 1'b0, 12'h005, 30'h0, 30'h15555555, "rd005_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
